// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with a main (head) and a skid slot.
// All outputs are registered, so there is no combinational in->out or out_ready->in_ready path.
module pipe_skid_reg #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] skid;

    // out_data is the head register; it keeps its last value while EMPTY
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            out_data  <= '0;
            skid      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= 2'd0;
        end else if (flush) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        out_data  <= in_data;
                        state     <= BUSY;
                        out_valid <= 1'b1;
                        count     <= 2'd1;
                    end
                end
                BUSY: begin
                    if (in_valid && out_ready) begin
                        out_data <= in_data;
                    end else if (in_valid) begin
                        skid     <= in_data;
                        state    <= FULL;
                        in_ready <= 1'b0;
                        count    <= 2'd2;
                    end else if (out_ready) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        count     <= 2'd0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so the input is never taken while draining skid
                    if (out_ready) begin
                        out_data <= skid;
                        state    <= BUSY;
                        in_ready <= 1'b1;
                        count    <= 2'd1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    count     <= 2'd0;
                end
            endcase
        end
    end

endmodule
